// File: rtl/inst_mem_ctrl.sv
// Instruction memory for the fetch stage: registered 1-cycle read with stall/flush, program-load port, LOAD->RUN boot FSM.
// Optional even-parity protection of the array is enabled by defining IMEM_PARITY_EN.
module inst_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter logic [DATA_W-1:0] NOP = {DATA_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_stop,
  input  logic              i_flush,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_done,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_fault,
  output logic              o_par_err
);

`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              par_err_q, par_err_d;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              wr_ok;
  logic              pc_ok;
  logic              par_bad;

`ifdef IMEM_PARITY_EN
  // Extra MSB makes the XOR of the whole stored word zero (even parity).
  assign wr_word = {^i_ld_data, i_ld_data};
`else
  assign wr_word = i_ld_data;
`endif

  assign wr_ok = i_ld_we && ({1'b0, i_ld_addr} < DEPTH_W);
  assign pc_ok = {1'b0, i_pc} < DEPTH_W;

  // Array has no reset so a loaded program survives i_reset.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem_q[i_ld_addr[IDX_W-1:0]] <= wr_word;
    end
  end

  // Write-first: a same-edge load to the fetched address is forwarded.
  assign rd_word = (wr_ok && (i_ld_addr == i_pc)) ? wr_word : mem_q[i_pc[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
  assign par_bad = ^rd_word;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_LOAD;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      par_err_q <= par_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    par_err_d = par_err_q;
    case (state_q)
      S_LOAD: begin
        if (i_ld_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          instr_d   = NOP;
          valid_d   = 1'b0;
          par_err_d = 1'b0;
        end else if (i_stop) begin
          instr_d   = instr_q;
        end else if (!pc_ok) begin
          instr_d   = NOP;
          valid_d   = 1'b0;
          fault_d   = 1'b1;
          par_err_d = 1'b0;
        end else begin
          // Raw data is still presented on a parity error; only valid drops.
          instr_d   = rd_word[DATA_W-1:0];
          valid_d   = !par_bad;
          par_err_d = par_bad;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_ready       = (state_q == S_RUN);
  assign o_fault       = fault_q;
  assign o_par_err     = par_err_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl (DEPTH=3000): directed load/fetch/stall/flush/fault/reset vectors.
module tb_inst_mem_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [11:0] i_pc;
  logic        i_stop;
  logic        i_flush;
  logic        i_ld_we;
  logic [11:0] i_ld_addr;
  logic [15:0] i_ld_data;
  logic        i_ld_done;
  logic [15:0] o_instruction;
  logic        o_valid;
  logic        o_ready;
  logic        o_fault;
  logic        o_par_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic        ready;
    logic        fault;
    logic        par;
  } exp_t;

  exp_t exp_q[$];

  inst_mem_ctrl #(.DATA_W(16), .ADDR_W(12), .DEPTH(3000), .NOP(16'h0000)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .i_stop(i_stop), .i_flush(i_flush),
    .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .i_ld_done(i_ld_done),
    .o_instruction(o_instruction), .o_valid(o_valid), .o_ready(o_ready),
    .o_fault(o_fault), .o_par_err(o_par_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".instr"}, o_instruction, e.instr);
    chk({tag, ".valid"}, {15'd0, o_valid}, {15'd0, e.valid});
    chk({tag, ".ready"}, {15'd0, o_ready}, {15'd0, e.ready});
    chk({tag, ".fault"}, {15'd0, o_fault}, {15'd0, e.fault});
    chk({tag, ".par"}, {15'd0, o_par_err}, {15'd0, e.par});
  endtask

  // Monitor: one expectation per clock edge, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_all("fetch", e);
      end
    end
  end

  // Inputs are already set for this cycle; queue what the next edge must produce.
  task automatic step(input logic [15:0] instr, input logic valid, input logic ready,
                      input logic fault, input logic par);
    exp_t e;
    e.instr = instr; e.valid = valid; e.ready = ready; e.fault = fault; e.par = par;
    exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d, input logic [15:0] instr,
                      input logic valid, input logic ready, input logic fault);
    i_ld_we = 1'b1; i_ld_addr = a; i_ld_data = d;
    step(instr, valid, ready, fault, 1'b0);
    i_ld_we = 1'b0;
  endtask

  initial begin
    exp_t rst_e;
    int budget;
    rst_e.instr = 16'h0000; rst_e.valid = 1'b0; rst_e.ready = 1'b0; rst_e.fault = 1'b0; rst_e.par = 1'b0;
    i_reset = 1'b0; i_pc = '0; i_stop = 1'b0; i_flush = 1'b0;
    i_ld_we = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_ld_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_all("reset", rst_e);
    i_reset = 1'b1;

    // Program load; fetch disabled in LOAD
    load(12'd0,    16'h1438, 16'h0000, 1'b0, 1'b0, 1'b0);
    load(12'd1,    16'h282F, 16'h0000, 1'b0, 1'b0, 1'b0);
    load(12'd2,    16'h3A5C, 16'h0000, 1'b0, 1'b0, 1'b0);
    i_ld_done = 1'b1;
    step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    i_ld_done = 1'b0;

    i_pc = 12'd0; step(16'h1438, 1'b1, 1'b1, 1'b0, 1'b0);
    i_pc = 12'd1; step(16'h282F, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stall holds while pc moves on
    i_stop = 1'b1; i_pc = 12'd2;
    repeat (3) step(16'h282F, 1'b1, 1'b1, 1'b0, 1'b0);
    i_stop = 1'b0; step(16'h3A5C, 1'b1, 1'b1, 1'b0, 1'b0);

    // Flush beats stall; stall then holds the squashed output
    i_stop = 1'b1; i_flush = 1'b1; i_pc = 12'd0;
    step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b0; step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    i_stop = 1'b0; step(16'h1438, 1'b1, 1'b1, 1'b0, 1'b0);

    // Out-of-range fetch, sticky fault
    i_pc = 12'd3000; step(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    i_pc = 12'd1;    step(16'h282F, 1'b1, 1'b1, 1'b1, 1'b0);
    i_pc = 12'd4095; step(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Dropped out-of-range write; last-word bypass and readback
    i_pc = 12'd0;    load(12'd3000, 16'hFFFF, 16'h1438, 1'b1, 1'b1, 1'b1);
    i_pc = 12'd2999; load(12'd2999, 16'h7E7E, 16'h7E7E, 1'b1, 1'b1, 1'b1);
    step(16'h7E7E, 1'b1, 1'b1, 1'b1, 1'b0);

    // Write-first collision
    i_pc = 12'd5; load(12'd5, 16'h1121, 16'h1121, 1'b1, 1'b1, 1'b1);
    step(16'h1121, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    #2 i_reset = 1'b0;
    #1 chk_all("async_reset", rst_e);
    @(negedge i_clk);
    i_reset = 1'b1;
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ld_done = 1'b1; step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    i_ld_done = 1'b0; step(16'h1121, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.mem_q[2][16] = ~dut.mem_q[2][16];
    i_pc = 12'd2; step(16'h3A5C, 1'b0, 1'b1, 1'b0, 1'b1);
    i_pc = 12'd1; step(16'h282F, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
